// File: rtl/dmem_arb.sv
// Two-requester arbiter for the 32-bit data SRAM: the core LSU has priority, and
// a starvation counter forces a debug/loader slot after STARVE_LIM denied cycles.
module dmem_arb #(
   parameter int AW         = 14,
   parameter int STARVE_LIM = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   core_a,
   input  logic [3:0]    core_we,
   input  logic [31:0]   core_wd,
   input  logic [3:0]    core_re,
   output logic [31:0]   core_rd,
   output logic          core_hold,
   input  logic          dbg_req,
   input  logic          dbg_wr,
   input  logic [3:0]    dbg_be,
   input  logic [15:0]   dbg_a,
   input  logic [31:0]   dbg_wd,
   output logic          dbg_gnt,
   output logic          dbg_rvld,
   output logic [31:0]   dbg_rd,
   output logic [AW-1:0] sram_a,
   output logic [3:0]    sram_we,
   output logic [31:0]   sram_wd,
   output logic [3:0]    sram_re,
   input  logic [31:0]   sram_rd
);

   localparam logic [7:0] LIM = 8'(STARVE_LIM);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CORE_RD,
      OWN_DBG_RD
   } own_t;

   own_t        own_q, own_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [31:0] core_rd_q, core_rd_d;

   logic core_act;
   logic core_gnt;

   // Only the word-address bits are routed; the byte-lane bits and upper bits
   // are folded here so they do not appear as dangling inputs.
   logic unused_addr;
   assign unused_addr = ^{core_a, dbg_a};

   always_comb begin
      core_act  = (|core_we) | (|core_re);
      dbg_gnt   = !rst & dbg_req & (!core_act | (wcnt_q == LIM));
      core_hold = !rst & core_act & dbg_gnt;
      core_gnt  = !rst & core_act & !core_hold;
   end

   // SRAM request mux: debug wins only when it holds the grant.
   always_comb begin
      sram_a  = core_a[AW+1:2];
      sram_wd = core_wd;
      sram_we = 4'h0;
      sram_re = 4'h0;
      if (dbg_gnt) begin
         sram_a  = dbg_a[AW+1:2];
         sram_wd = dbg_wd;
         sram_we = dbg_wr ? dbg_be : 4'h0;
         sram_re = dbg_wr ? 4'h0 : dbg_be;
      end else if (core_gnt) begin
         sram_we = core_we;
         sram_re = core_re;
      end
   end

   always_comb begin
      wcnt_d = wcnt_q;
      if (dbg_gnt || !dbg_req) begin
         wcnt_d = 8'd0;
      end else if (wcnt_q < LIM) begin
         wcnt_d = wcnt_q + 8'd1;
      end
   end

   always_comb begin
      own_d = OWN_NONE;
      if (dbg_gnt && !dbg_wr && (|dbg_be)) begin
         own_d = OWN_DBG_RD;
      end else if (core_gnt && (|core_re)) begin
         own_d = OWN_CORE_RD;
      end
   end

   // Return path: the SRAM answers one cycle after the access, so own_q
   // tells us who issued the read that is now on sram_rd.
   always_comb begin
      dbg_rvld  = (own_q == OWN_DBG_RD);
      dbg_rd    = dbg_rvld ? sram_rd : 32'h0;
      core_rd_d = (own_q == OWN_CORE_RD) ? sram_rd : core_rd_q;
      core_rd   = core_rd_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own_q     <= OWN_NONE;
         wcnt_q    <= 8'd0;
         core_rd_q <= 32'h0;
      end else begin
         own_q     <= own_d;
         wcnt_q    <= wcnt_d;
         core_rd_q <= core_rd_d;
      end
   end

endmodule

// File: doc/dmem_arb.md
# dmem_arb

Two-requester arbiter for the 32-bit data SRAM. Sits between the core's LSU data port (dat_a/dat_we/dat_wd/dat_re/dat_rd) and the SRAM macro, and shares the SRAM with a debug/loader port (valid/grant handshake). The core has priority. A starvation counter guarantees the debug port a slot within STARVE_LIM cycles, stalling the core for one cycle when it forces a grant. Read data is routed back to the owner of the access one cycle after grant, matching the SRAM's registered-input, one-cycle read behaviour.

## Interface
- AW, 14, SRAM word-address width; the SRAM holds 2**AW 32-bit words.
- STARVE_LIM, 8, maximum consecutive denied cycles for the debug port, 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- core_a  in  16  core byte address; bits [AW+1:2] are used.
- core_we  in  4  core byte write enables.
- core_wd  in  32  core write data.
- core_re  in  4  core byte read enables.
- core_rd  out  32  core read data.
- core_hold  out  1  core access denied this cycle; the core must re-present the identical request next cycle.
- dbg_req  in  1  debug access request.
- dbg_wr  in  1  1 = write, 0 = read.
- dbg_be  in  4  debug byte enables.
- dbg_a  in  16  debug byte address.
- dbg_wd  in  32  debug write data.
- dbg_gnt  out  1  debug access accepted this cycle.
- dbg_rvld  out  1  debug read data valid.
- dbg_rd  out  32  debug read data; 0 when dbg_rvld = 0.
- sram_a  out  AW  SRAM word address.
- sram_we  out  4  SRAM byte write enables.
- sram_wd  out  32  SRAM write data.
- sram_re  out  4  SRAM byte read enables.
- sram_rd  in  32  SRAM read data, valid the cycle after the access.

## Operation
- core_act = |core_we | |core_re.
- Grant rule: dbg_gnt = !rst & dbg_req & (!core_act | wcnt == STARVE_LIM). This is combinational.
- core_hold = !rst & core_act & dbg_gnt.
- Core gets the SRAM whenever core_act = 1 and core_hold = 0.
- Wait counter wcnt, width 8, reset 0:
  - Cleared when dbg_gnt = 1 or dbg_req = 0.
  - Otherwise incremented, saturating at STARVE_LIM.
- SRAM mux when dbg_gnt = 1:
  - sram_a = dbg_a[AW+1:2], sram_wd = dbg_wd.
  - sram_we = dbg_wr ? dbg_be : 0; sram_re = dbg_wr ? 0 : dbg_be.
- SRAM mux otherwise:
  - sram_a = core_a[AW+1:2], sram_we = core_we, sram_wd = core_wd, sram_re = core_re.
  - When core_hold = 1, sram_we and sram_re are 0.
- During rst: sram_we = 0, sram_re = 0, dbg_gnt = 0, core_hold = 0.
- Owner register own_q with states NONE, CORE_RD, DBG_RD; reset NONE. Next value:
  - DBG_RD if dbg_gnt & !dbg_wr & |dbg_be.
  - else CORE_RD if core granted & |core_re.
  - else NONE.
- Return path:
  - dbg_rvld = (own_q == DBG_RD); dbg_rd = dbg_rvld ? sram_rd : 0.
  - core_rd = sram_rd when own_q == CORE_RD; otherwise holds its last value (register, reset 0).
- Writes produce no response. A write is complete once granted.
- Debug read of a word written by the core in the previous cycle returns the new data; SRAM ordering applies.

## Timing
- Grant and hold are decided in the same cycle as the request (0 latency).
- Read data returns exactly 1 cycle after grant. Back-to-back grants give one result per cycle, in grant order.
- A continuously requesting core is held at most 1 cycle in every STARVE_LIM+1 cycles.
- Debug worst-case wait is STARVE_LIM cycles.
- rst asserted mid-read clears own_q; the pending dbg_rvld is dropped and not replayed.
- Reset values: dbg_gnt 0, core_hold 0, dbg_rvld 0, dbg_rd 0, core_rd 0, sram_we 0, sram_re 0, wcnt 0.

## Test plan
- Core only: core_re = 4'hF at address 0x40, with SRAM word 0x10 = 0xDEADBEEF -> sram_a = 0x10 the same cycle; core_rd = 0xDEADBEEF next cycle; dbg_rvld stays 0.
- Debug into idle core: dbg_req = 1, dbg_wr = 1, dbg_be = 4'h3, dbg_a = 0x8, dbg_wd = 0x12345678 -> dbg_gnt = 1 same cycle, sram_we = 4'h3, sram_a = 2; a following debug read returns 0x????5678, with dbg_rvld = 1 one cycle after that read's grant.
- Starvation, STARVE_LIM = 8: core_re = 4'hF every cycle, dbg_req held high -> dbg_gnt = 0 for 8 cycles; on the 9th cycle dbg_gnt = 1 and core_hold = 1; the next cycle core is granted and wcnt = 0.
- Back-to-back mixed reads, core then debug, in consecutive cycles -> core_rd then dbg_rd carry the correct words in consecutive cycles; no cross-routing.
- Reset mid-read: debug read granted, rst asserted before the next edge -> dbg_rvld = 0; all outputs at reset values; normal grants resume after rst deasserts.
- Both idle -> sram_we = 0, sram_re = 0, dbg_gnt = 0, core_hold = 0, wcnt stays 0.
